bus_decoder: RTL and testbench
==============================

BUS_DECODER -- requirements
Module: bus_decoder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: width of the master and slave address.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: width of write and read data.
REQ-003 SHALL have parameter TIMEOUT, default 15: maximum number of ACCESS cycles before an error response; legal range 1..255.
REQ-004 SHALL have port clk_i, input, 1: the single clock; all logic SHALL be rising-edge clocked.
REQ-005 SHALL have port rst_i, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port m_valid_i, input, 1: master request valid.
REQ-007 SHALL have port m_ready_o, output, 1: the block can accept a request.
REQ-008 SHALL have port m_addr_i, input, ADDR_WIDTH: request address.
REQ-009 SHALL have port m_we_i, input, 1: write enable (1 = write, 0 = read).
REQ-010 SHALL have port m_wdata_i, input, DATA_WIDTH: write data.
REQ-011 SHALL have port m_resp_valid_o, output, 1: one-cycle response strobe.
REQ-012 SHALL have port m_rdata_o, output, DATA_WIDTH: read data, valid while m_resp_valid_o is high.
REQ-013 SHALL have port m_err_o, output, 1: error flag, valid while m_resp_valid_o is high.
REQ-014 SHALL have port s_sel_o, output, 4: one-hot slave select, driving the select input of the downstream 4-way demux.
REQ-015 SHALL have port s_addr_o, output, ADDR_WIDTH: latched address, broadcast to all slaves.
REQ-016 SHALL have port s_we_o, output, 1: latched write enable, broadcast to all slaves.
REQ-017 SHALL have port s_wdata_o, output, DATA_WIDTH: latched write data, broadcast to all slaves.
REQ-018 SHALL have port s_rdata_i, input, 4*DATA_WIDTH: packed slave read data; slave k occupies bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH].
REQ-019 SHALL have port s_ready_i, input, 4: per-slave completion strobe.

Function
REQ-020 SHALL implement a three-state FSM with states IDLE, ACCESS and RESP.
REQ-021 IDLE: m_ready_o=1, s_sel_o=0; a request SHALL be accepted when m_valid_i and m_ready_o are both high.
REQ-022 On accept, the block SHALL latch addr/we/wdata into s_addr_o/s_we_o/s_wdata_o and decode addr[ADDR_WIDTH-1:ADDR_WIDTH-4].
REQ-023 Decode: nibble 0x0..0x3 SHALL select slave 0..3; any other nibble SHALL be a decode miss.
REQ-024 On a hit, the FSM SHALL enter ACCESS next cycle with the decoded bit of s_sel_o set and the timeout counter cleared.
REQ-025 On a miss, the FSM SHALL enter RESP directly with err=1, rdata=0, and no s_sel_o bit ever set.
REQ-026 ACCESS: m_ready_o=0; s_sel_o is held and the counter increments every cycle.
REQ-027 In ACCESS, only s_ready_i of the selected slave SHALL be honoured; all other ready bits are ignored.
REQ-028 In ACCESS, s_ready_i[sel] high SHALL register that slave's s_rdata_i slice (0 on write) into m_rdata_o, set err=0, and enter RESP.
REQ-029 In ACCESS, if the counter reaches TIMEOUT without ready, the block SHALL set err=1 and rdata=0 and enter RESP; ready and timeout in the same cycle SHALL resolve as ready.
REQ-030 RESP: m_resp_valid_o=1 for exactly one cycle, s_sel_o=0, m_ready_o=0, then return to IDLE.
REQ-031 Latency: accept at cycle N with ready at cycle N+1 SHALL give m_resp_valid_o at N+2; decode miss SHALL give m_resp_valid_o at N+1.
REQ-032 m_rdata_o and m_err_o SHALL hold their values until the next response.
REQ-033 Back-to-back: a new request SHALL be acceptable in the cycle after RESP.

Reset
REQ-034 rst_i high SHALL immediately force IDLE, clear the counter, and drive all outputs to 0 except m_ready_o; m_ready_o SHALL be 1 once rst_i deasserts.
REQ-035 Reset during ACCESS or RESP SHALL abort the transaction with no response strobe.

Structure
REQ-036 Package tiny_soc_bus_pkg SHALL hold the FSM state type, N_SLAVES=4, the slave-index nibble constants and the default TIMEOUT.
REQ-037 The block SHALL contain no sub-module; s_sel_o connects externally to the demux, and the rdata slice select is inline.

Verification
REQ-038 Read at 0x1000_0004 with s_ready_i=4'b0010 one cycle later, slice 1=0xDEAD_BEEF -> s_sel_o=4'b0010 for 1 cycle; resp at N+2 with rdata=0xDEAD_BEEF, err=0.
REQ-039 Write to 0x3000_0000 with wdata 0x1234_5678 -> s_sel_o=4'b1000, s_wdata_o=0x1234_5678, s_we_o=1; resp err=0, rdata=0.
REQ-040 Access to 0x8000_0000 -> s_sel_o stays 0; resp at N+1 with err=1, rdata=0.
REQ-041 Access to slave 2 with s_ready_i held at 0 -> resp after TIMEOUT=15 ACCESS cycles with err=1; s_sel_o cleared in RESP.
REQ-042 Access to slave 0 with s_ready_i=4'b1110 (wrong slaves) -> ignored; the access times out with err=1.
REQ-043 rst_i asserted mid-ACCESS -> outputs 0 asynchronously, no m_resp_valid_o, m_ready_o=1 after release.

Source files
------------

// File: rtl/tiny_soc_bus_pkg.sv
// Shared types and constants for the tiny SoC bus decoder.
// Holds the FSM state encoding, slave count, address-nibble map and default timeout.
package tiny_soc_bus_pkg;

  localparam int unsigned N_SLAVES        = 4;
  localparam int unsigned DEFAULT_TIMEOUT = 15;

  localparam logic [3:0] SLV0_NIBBLE = 4'h0;
  localparam logic [3:0] SLV1_NIBBLE = 4'h1;
  localparam logic [3:0] SLV2_NIBBLE = 4'h2;
  localparam logic [3:0] SLV3_NIBBLE = 4'h3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Top address nibble maps to a slave only for the four low nibble values.
  function automatic logic nibble_hit(input logic [3:0] nib);
    return (nib == SLV0_NIBBLE) || (nib == SLV1_NIBBLE) ||
           (nib == SLV2_NIBBLE) || (nib == SLV3_NIBBLE);
  endfunction

  function automatic logic [N_SLAVES-1:0] idx_to_sel(input logic [1:0] idx);
    return N_SLAVES'(1) << idx;
  endfunction

endpackage

// File: rtl/bus_decoder.sv
// Single-master to four-slave address decoder with a per-access timeout.
// One outstanding request; response strobe, data and error are registered.
module bus_decoder
  import tiny_soc_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         m_valid_i,
  output logic                         m_ready_o,
  input  logic [ADDR_WIDTH-1:0]        m_addr_i,
  input  logic                         m_we_i,
  input  logic [DATA_WIDTH-1:0]        m_wdata_i,
  output logic                         m_resp_valid_o,
  output logic [DATA_WIDTH-1:0]        m_rdata_o,
  output logic                         m_err_o,
  output logic [N_SLAVES-1:0]          s_sel_o,
  output logic [ADDR_WIDTH-1:0]        s_addr_o,
  output logic                         s_we_o,
  output logic [DATA_WIDTH-1:0]        s_wdata_o,
  input  logic [N_SLAVES*DATA_WIDTH-1:0] s_rdata_i,
  input  logic [N_SLAVES-1:0]          s_ready_i
);

  localparam int unsigned CNT_W = 8;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [1:0]              idx_q, idx_d;
  logic                    ready_q, ready_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [N_SLAVES-1:0]     sel_q, sel_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    we_q, we_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

  logic [3:0]              nib_c;
  logic                    hit_c;
  logic                    accept_c;
  logic                    sel_ready_c;
  logic                    timeout_c;
  logic [DATA_WIDTH-1:0]   slice_c;

  assign nib_c       = m_addr_i[ADDR_WIDTH-1 -: 4];
  assign hit_c       = nibble_hit(nib_c);
  assign accept_c    = m_valid_i && (state_q == ST_IDLE);
  assign sel_ready_c = s_ready_i[idx_q];
  assign timeout_c   = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign slice_c     = s_rdata_i[32'(idx_q) * DATA_WIDTH +: DATA_WIDTH];

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; ready beats timeout when both occur together
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept_c) state_d = hit_c ? ST_ACCESS : ST_RESP;
      ST_ACCESS: if (sel_ready_c || timeout_c) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    sel_d        = '0;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    ready_d      = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          addr_d  = m_addr_i;
          we_d    = m_we_i;
          wdata_d = m_wdata_i;
          cnt_d   = '0;
          idx_d   = nib_c[1:0];
          if (hit_c) begin
            sel_d = idx_to_sel(nib_c[1:0]);
          end else begin
            rdata_d = '0;
            err_d   = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        sel_d = sel_q;
        cnt_d = cnt_q + CNT_W'(1);
        if (sel_ready_c) begin
          rdata_d = we_q ? '0 : slice_c;
          err_d   = 1'b0;
          sel_d   = '0;
        end else if (timeout_c) begin
          rdata_d = '0;
          err_d   = 1'b1;
          sel_d   = '0;
        end
      end
      default: ;
    endcase
  end

  // Output / datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      sel_q        <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      sel_q        <= sel_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
    end
  end

  assign m_ready_o      = ready_q;
  assign m_resp_valid_o = resp_valid_q;
  assign m_rdata_o      = rdata_q;
  assign m_err_o        = err_q;
  assign s_sel_o        = sel_q;
  assign s_addr_o       = addr_q;
  assign s_we_o         = we_q;
  assign s_wdata_o      = wdata_q;

endmodule

// File: tb/tb_bus_decoder.sv
// Directed, table-driven bench for bus_decoder: decode, latency, timeout,
// ready masking, back-to-back traffic and asynchronous reset abort.
module tb_bus_decoder;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         m_valid_i;
  logic         m_ready_o;
  logic [31:0]  m_addr_i;
  logic         m_we_i;
  logic [31:0]  m_wdata_i;
  logic         m_resp_valid_o;
  logic [31:0]  m_rdata_o;
  logic         m_err_o;
  logic [3:0]   s_sel_o;
  logic [31:0]  s_addr_o;
  logic         s_we_o;
  logic [31:0]  s_wdata_o;
  logic [127:0] s_rdata_i;
  logic [3:0]   s_ready_i;

  int n_total = 0;
  int n_pass  = 0;

  bus_decoder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(15)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_valid_i(m_valid_i), .m_ready_o(m_ready_o), .m_addr_i(m_addr_i),
    .m_we_i(m_we_i), .m_wdata_i(m_wdata_i),
    .m_resp_valid_o(m_resp_valid_o), .m_rdata_o(m_rdata_o), .m_err_o(m_err_o),
    .s_sel_o(s_sel_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_wdata_o(s_wdata_o),
    .s_rdata_i(s_rdata_i), .s_ready_i(s_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  rdy;
    int          dly;
    logic [3:0]  sel;
    int          lat;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Runs one transaction starting in an IDLE cycle (called #1 after an edge).
  task automatic run_vec(input int k, input vec_t v);
    int          lat;
    int          acc;
    int          sel_bad;
    logic [3:0]  sel_acc;
    string       tag;
    tag = $sformatf("v%0d", k);
    check({tag, "_ready_idle"}, 32'(m_ready_o), 32'd1);
    m_valid_i = 1'b1;
    m_addr_i  = v.addr;
    m_we_i    = v.we;
    m_wdata_i = v.wdata;
    tick();
    m_valid_i = 1'b0;
    m_addr_i  = 32'h0;
    m_wdata_i = 32'h0;
    m_we_i    = 1'b0;
    check({tag, "_s_addr"}, s_addr_o, v.addr);
    check({tag, "_s_we"}, 32'(s_we_o), 32'(v.we));
    check({tag, "_s_wdata"}, s_wdata_o, v.wdata);
    lat = 1; acc = 0; sel_bad = 0; sel_acc = 4'b0;
    while (!m_resp_valid_o && lat < 40) begin
      sel_acc |= s_sel_o;
      if (s_sel_o !== v.sel) sel_bad++;
      if (m_ready_o !== 1'b0) sel_bad++;
      s_ready_i = (acc >= v.dly) ? v.rdy : 4'b0;
      acc++;
      tick();
      lat++;
    end
    s_ready_i = 4'b0;
    check({tag, "_sel_seen"}, 32'(sel_acc), 32'(v.sel));
    check({tag, "_access_stable"}, 32'(sel_bad), 32'd0);
    check({tag, "_latency"}, 32'(lat), 32'(v.lat));
    check({tag, "_resp_valid"}, 32'(m_resp_valid_o), 32'd1);
    check({tag, "_err"}, 32'(m_err_o), 32'(v.err));
    check({tag, "_rdata"}, m_rdata_o, v.rdata);
    check({tag, "_sel_in_resp"}, 32'(s_sel_o), 32'd0);
    check({tag, "_ready_in_resp"}, 32'(m_ready_o), 32'd0);
    tick();
    check({tag, "_resp_one_cycle"}, 32'(m_resp_valid_o), 32'd0);
    check({tag, "_rdata_hold"}, m_rdata_o, v.rdata);
    check({tag, "_err_hold"}, 32'(m_err_o), 32'(v.err));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_resp_valid"}, 32'(m_resp_valid_o), 32'd0);
    check({tag, "_sel"}, 32'(s_sel_o), 32'd0);
    check({tag, "_rdata"}, m_rdata_o, 32'd0);
    check({tag, "_err"}, 32'(m_err_o), 32'd0);
    check({tag, "_s_addr"}, s_addr_o, 32'd0);
    check({tag, "_s_wdata"}, s_wdata_o, 32'd0);
    check({tag, "_s_we"}, 32'(s_we_o), 32'd0);
  endtask

  initial begin
    int strobes;
    vecs[0] = '{32'h1000_0004, 1'b0, 32'h0,         4'b0010, 0,  4'b0010, 2,  1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{32'h3000_0000, 1'b1, 32'h1234_5678, 4'b1000, 0,  4'b1000, 2,  1'b0, 32'h0};
    vecs[2] = '{32'h8000_0000, 1'b0, 32'h0,         4'b1111, 0,  4'b0000, 1,  1'b1, 32'h0};
    vecs[3] = '{32'h0000_0040, 1'b0, 32'h0,         4'b0001, 3,  4'b0001, 5,  1'b0, 32'hA5A5_0001};
    vecs[4] = '{32'h2000_0010, 1'b0, 32'h0,         4'b0000, 0,  4'b0100, 16, 1'b1, 32'h0};
    vecs[5] = '{32'h2000_0020, 1'b0, 32'h0,         4'b0100, 0,  4'b0100, 2,  1'b0, 32'hCAFE_0002};
    vecs[6] = '{32'h0000_0000, 1'b0, 32'h0,         4'b1110, 0,  4'b0001, 16, 1'b1, 32'h0};
    vecs[7] = '{32'h3FFF_FFFC, 1'b0, 32'h0,         4'b1000, 14, 4'b1000, 16, 1'b0, 32'h0BAD_0003};
    vecs[8] = '{32'hF000_0000, 1'b1, 32'h5555_AAAA, 4'b1111, 0,  4'b0000, 1,  1'b1, 32'h0};
    vecs[9] = '{32'h4000_0000, 1'b0, 32'h0,         4'b1111, 0,  4'b0000, 1,  1'b1, 32'h0};

    rst_i     = 1'b1;
    m_valid_i = 1'b0;
    m_addr_i  = 32'h0;
    m_we_i    = 1'b0;
    m_wdata_i = 32'h0;
    s_ready_i = 4'b0;
    s_rdata_i = {32'h0BAD_0003, 32'hCAFE_0002, 32'hDEAD_BEEF, 32'hA5A5_0001};

    tick();
    tick();
    check_reset_outputs("reset");
    rst_i = 1'b0;
    tick();
    check("ready_after_reset", 32'(m_ready_o), 32'd1);

    for (int k = 0; k < 10; k++) run_vec(k, vecs[k]);

    // Reset in the middle of an access aborts it without a response.
    m_valid_i = 1'b1;
    m_addr_i  = 32'h1000_0000;
    m_wdata_i = 32'h7777_7777;
    tick();
    m_valid_i = 1'b0;
    check("abort_sel_before", 32'(s_sel_o), 32'h2);
    tick();
    tick();
    #2 rst_i = 1'b1;
    #1;
    check_reset_outputs("abort_async");
    tick();
    rst_i = 1'b0;
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_resp_valid_o) strobes++;
      tick();
    end
    check("abort_no_strobe", 32'(strobes), 32'd0);
    check("abort_ready_after", 32'(m_ready_o), 32'd1);

    // Reset landing on the response cycle kills the strobe.
    m_valid_i = 1'b1;
    m_addr_i  = 32'hC000_0000;
    tick();
    m_valid_i = 1'b0;
    check("resp_abort_strobe_before", 32'(m_resp_valid_o), 32'd1);
    #1 rst_i = 1'b1;
    #1;
    check("resp_abort_strobe", 32'(m_resp_valid_o), 32'd0);
    check("resp_abort_err", 32'(m_err_o), 32'd0);
    tick();
    rst_i = 1'b0;
    tick();
    check("resp_abort_ready", 32'(m_ready_o), 32'd1);
    check("resp_abort_idle_strobe", 32'(m_resp_valid_o), 32'd0);

    run_vec(10, vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
